// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - Wishbone widths and arbiter state encoding shared by the bus blocks
package wb_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = WB_DW / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational round-robin picker, searches upward from last_i+1 with wrap
module wb_rr_pick
  import wb_pkg::*;
#(
  parameter int NM = 2,
  parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  int c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = 0;
    for (int k = 1; k <= NM; k++) begin
      c = (int'(last_i) + k) % NM;
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin Wishbone master arbiter with a no-ack bus watchdog
module wb_bus_arbiter
  import wb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rstn_i,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  output logic [DW-1:0]      m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [DW/8-1:0]    wbm_sel_o,
  output logic [AW-1:0]      wbm_adr_o,
  output logic [DW-1:0]      wbm_dat_o,
  input  logic [DW-1:0]      wbm_dat_i,
  input  logic               wbm_ack_i,
  output logic [NM-1:0]      gnt_o
);

  localparam int SELW = DW / 8;
  localparam int IW   = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] TO_SAT  = CW'(TIMEOUT);

  wb_state_e     state_q, state_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_pend_q, err_pend_d;

  logic [NM-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          busy_act;

  wb_rr_pick #(.NM(NM), .IW(IW)) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  // The owner's cyc gates everything, so a dropped cyc releases the bus in the same cycle.
  assign busy_act  = (state_q == BUSY) && m_cyc_i[idx_q];
  assign wbm_cyc_o = busy_act;
  assign wbm_stb_o = busy_act && m_stb_i[idx_q] && !err_pend_q;
  assign wbm_we_o  = busy_act && m_we_i[idx_q];
  assign wbm_sel_o = busy_act ? m_sel_i[int'(idx_q)*SELW +: SELW] : '0;
  assign wbm_adr_o = busy_act ? m_adr_i[int'(idx_q)*AW +: AW] : '0;
  assign wbm_dat_o = busy_act ? m_dat_i[int'(idx_q)*DW +: DW] : '0;

  assign m_ack_o = gnt_q & {NM{wbm_ack_i}};
  assign m_err_o = (busy_act && err_pend_q) ? gnt_q : '0;
  assign m_dat_o = (state_q == BUSY) ? wbm_dat_i : '0;
  assign gnt_o   = gnt_q;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= IW'(NM - 1);
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        err_pend_d = 1'b0;
        if (pick_vld) begin
          state_d = BUSY;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
        end
      end
      BUSY: begin
        if (!m_cyc_i[idx_q]) begin
          state_d    = IDLE;
          gnt_d      = '0;
          last_d     = idx_q;
          cnt_d      = '0;
          err_pend_d = 1'b0;
        end else if (err_pend_q) begin
          err_pend_d = 1'b0;
          cnt_d      = '0;
        end else if (TIMEOUT != 0 && wbm_stb_o && !wbm_ack_i) begin
          // An ack in the final wait cycle takes the else branch, so it beats the timeout.
          if (cnt_q == TO_LAST) err_pend_d = 1'b1;
          if (cnt_q != TO_SAT) cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - scoreboard bench for the round-robin Wishbone arbiter
module tb_wb_bus_arbiter;

  localparam int NM      = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              rst_n;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*DW/8-1:0] m_sel;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, gnt_o;
  logic              wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [DW/8-1:0]   wbm_sel_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic [DW-1:0]     wbm_dat_i;
  logic              wbm_ack_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] dat;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_r;

  wb_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_sel_i   (m_sel),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .gnt_o     (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] e, input logic [31:0] d);
    resp_t r;
    r.ack = a;
    r.err = e;
    r.dat = d;
    exp_q.push_back(r);
  endtask

  // Every ack/err pulse the DUT produces must match the next queued expectation.
  always @(negedge clk) begin
    if (|m_ack_o || |m_err_o) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'({m_ack_o, m_err_o}), 64'h0);
      end else begin
        mon_r = exp_q.pop_front();
        check("resp_ack", 64'(m_ack_o), 64'(mon_r.ack));
        check("resp_err", 64'(m_err_o), 64'(mon_r.err));
        if (mon_r.ack != 2'b00) check("resp_dat", 64'(m_dat_o), 64'(mon_r.dat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic found;

    rst_n     = 1'b0;
    m_cyc     = 2'b11;
    m_stb     = 2'b00;
    m_we      = 2'b00;
    m_sel     = 8'hC3;
    m_adr     = {32'h2100_0000, 32'h1000_0000};
    m_dat     = {32'h1111_1111, 32'h0000_CAFE};
    wbm_dat_i = 32'hDEAD_BEEF;
    wbm_ack_i = 1'b0;

    // reset state, then contention straight out of reset
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_cyc", 64'(wbm_cyc_o), 64'h0);
    check("rst_adr", 64'(wbm_adr_o), 64'h0);
    check("rst_mdat", 64'(m_dat_o), 64'h0);
    check("rst_err", 64'(m_err_o), 64'h0);
    drive_slot(); rst_n = 1'b1;
    @(negedge clk); check("arb_lat_gnt", 64'(gnt_o), 64'h0);
    @(negedge clk);
    check("arb_gnt_m0", 64'(gnt_o), 64'h1);
    check("arb_cyc", 64'(wbm_cyc_o), 64'h1);
    check("arb_adr_m0", 64'(wbm_adr_o), 64'h1000_0000);
    check("arb_wdat_m0", 64'(wbm_dat_o), 64'h0000_CAFE);
    drive_slot(); m_cyc[0] = 1'b0;
    @(negedge clk); check("drop_cyc_comb", 64'(wbm_cyc_o), 64'h0);
    @(negedge clk); check("idle_gnt", 64'(gnt_o), 64'h0);
    @(negedge clk); check("rr_gnt_m1", 64'(gnt_o), 64'h2);

    // master 1 read with a 3-cycle slave
    drive_slot(); m_stb[1] = 1'b1;
    @(negedge clk);
    check("rd_adr", 64'(wbm_adr_o), 64'h2100_0000);
    check("rd_stb", 64'(wbm_stb_o), 64'h1);
    check("rd_sel", 64'(wbm_sel_o), 64'hC);
    check("rd_we", 64'(wbm_we_o), 64'h0);
    drive_slot();
    drive_slot(); wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_0001; push(2'b10, 2'b00, 32'hA5A5_0001);
    @(negedge clk); check("rd_ack_m0_low", 64'(m_ack_o[0]), 64'h0);
    drive_slot(); wbm_ack_i = 1'b0; m_stb[1] = 1'b0;
    @(negedge clk); check("rd_ack_1cyc", 64'(m_ack_o), 64'h0);
    drive_slot(); m_cyc[1] = 1'b0;
    drive_slot();

    // watchdog: no ack for TIMEOUT stb cycles
    m_adr[31:0] = 32'h3000_0000; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    push(2'b00, 2'b01, 32'h0);
    n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_err_o[0]) begin
        found = 1'b1;
        check("to_stb_in_err", 64'(wbm_stb_o), 64'h0);
      end else if (wbm_stb_o) begin
        n++;
      end
    end
    check("to_err_seen", 64'(found), 64'h1);
    check("to_stb_cycles", 64'(n), 64'd8);
    @(negedge clk);
    check("to_err_1cyc", 64'(m_err_o), 64'h0);
    check("to_stb_resume", 64'(wbm_stb_o), 64'h1);
    drive_slot(); m_cyc = 2'b00; m_stb = 2'b00;
    drive_slot();

    // ack on the last permitted stb cycle wins over the timeout
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    drive_slot();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0808; push(2'b01, 2'b00, 32'h0000_0808);
      end
      @(negedge clk);
      check("ack8_stb", 64'(wbm_stb_o), 64'h1);
      if (i == 8) check("ack8_m_ack", 64'(m_ack_o), 64'h1);
      else drive_slot();
    end
    drive_slot(); wbm_ack_i = 1'b0;
    @(negedge clk); check("ack8_no_err", 64'(m_err_o), 64'h0);
    drive_slot(); m_cyc = 2'b00; m_stb = 2'b00;
    drive_slot();

    // master 0 holds cyc over 4 phases while master 1 waits
    m_cyc = 2'b01;
    drive_slot(); m_cyc = 2'b11;
    @(negedge clk); check("burst_gnt_start", 64'(gnt_o), 64'h1);
    for (int p = 0; p < 4; p++) begin
      drive_slot(); m_stb[0] = 1'b1; wbm_ack_i = 1'b1; wbm_dat_i = 32'hB000_0000 + 32'(p);
      push(2'b01, 2'b00, 32'hB000_0000 + 32'(p));
      @(negedge clk); check("burst_gnt_phase", 64'(gnt_o), 64'h1);
      drive_slot(); m_stb[0] = 1'b0; wbm_ack_i = 1'b0;
      @(negedge clk); check("burst_gnt_gap", 64'(gnt_o), 64'h1);
    end
    drive_slot(); m_cyc[0] = 1'b0;
    @(negedge clk);
    @(negedge clk); check("burst_idle", 64'(gnt_o), 64'h0);
    @(negedge clk); check("burst_m1_gnt", 64'(gnt_o), 64'h2);
    drive_slot(); m_cyc = 2'b00;
    drive_slot();

    // asynchronous reset mid-transfer with an ack in flight
    m_cyc = 2'b01; m_stb = 2'b01;
    drive_slot();
    @(negedge clk); check("pre_rst_gnt", 64'(gnt_o), 64'h1);
    drive_slot(); rst_n = 1'b0; wbm_ack_i = 1'b1; wbm_dat_i = 32'h5A5A_5A5A;
    #1;
    check("arst_gnt", 64'(gnt_o), 64'h0);
    check("arst_cyc", 64'(wbm_cyc_o), 64'h0);
    check("arst_stb", 64'(wbm_stb_o), 64'h0);
    check("arst_adr", 64'(wbm_adr_o), 64'h0);
    check("arst_ack", 64'(m_ack_o), 64'h0);
    check("arst_err", 64'(m_err_o), 64'h0);
    check("arst_mdat", 64'(m_dat_o), 64'h0);
    drive_slot(); wbm_ack_i = 1'b0; m_cyc = 2'b11; m_stb = 2'b00; rst_n = 1'b1;
    @(negedge clk); check("post_rst_idle", 64'(gnt_o), 64'h0);
    @(negedge clk); check("post_rst_m0", 64'(gnt_o), 64'h1);
    drive_slot(); m_cyc = 2'b00;
    repeat (3) drive_slot();

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Round-robin Wishbone arbiter that sits directly upstream of the address-decoding interconnect.
- Multiplexes NM bus masters (management CPU, housekeeping SPI, debug) onto the single master port of the interconnect.
- Holds the grant for a whole cycle, i.e. until the owning master drops cyc.
- A bus watchdog returns an error to the master when no slave acknowledges within TIMEOUT cycles, which covers unmapped addresses where no slave_sel bit is set.

Parameters:
- NM, 2: number of masters (2..8).
- AW, 32: address width.
- DW, 32: data width; the select width is DW/8.
- TIMEOUT, 255: number of cycles stb may wait for ack before an error is returned; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  bus clock; all state changes on the rising edge.
- wb_rstn_i  in  1  reset, asynchronous, active-low.
- m_cyc_i  in  NM  per-master cycle request.
- m_stb_i  in  NM  per-master strobe.
- m_we_i  in  NM  per-master write enable.
- m_sel_i  in  NM*DW/8  per-master byte selects, packed with master 0 in the LSBs.
- m_adr_i  in  NM*AW  per-master address, packed the same way.
- m_dat_i  in  NM*DW  per-master write data, packed the same way.
- m_dat_o  out  DW  read data broadcast to all masters.
- m_ack_o  out  NM  per-master acknowledge.
- m_err_o  out  NM  per-master timeout error.
- wbm_cyc_o  out  1  cycle to the interconnect and slaves.
- wbm_stb_o  out  1  strobe to the interconnect.
- wbm_we_o  out  1  write enable to the slaves.
- wbm_sel_o  out  DW/8  byte selects to the slaves.
- wbm_adr_o  out  AW  address to the interconnect.
- wbm_dat_o  out  DW  write data to the slaves.
- wbm_dat_i  in  DW  read data from the interconnect.
- wbm_ack_i  in  1  acknowledge from the interconnect.
- gnt_o  out  NM  one-hot current grant, for debug; all zero when idle.

Behaviour:
- Reset (wb_rstn_i=0, asynchronous): state IDLE; gnt=0; last=NM-1, so master 0 has first priority; watchdog count=0; err register=0.
  - All wbm_* outputs are 0.
  - m_ack_o, m_err_o, m_dat_o are 0.
- State IDLE:
  - If any m_cyc_i is set, grant the first requester searching from (last+1) mod NM upward with wrap. Go to BUSY next cycle.
  - Arbitration latency is 1 cycle: the request is registered and the grant is visible on the following edge.
- State BUSY, granted index g:
  - wbm_adr/we/sel/dat/cyc follow master g combinationally.
  - wbm_stb_o = m_stb_i[g] & ~err_pending.
  - Non-granted masters see m_ack_o=0 and m_err_o=0.
- BUSY -> IDLE: when m_cyc_i[g]=0.
  - On that edge last<=g and gnt<=0.
  - That cycle's outputs are already deasserted combinationally.
  - A new grant can appear no earlier than 2 cycles after the cyc drop (one cycle in IDLE).
- Acknowledge path:
  - m_ack_o[g] = wbm_ack_i & gnt[g], combinational (zero added latency).
  - m_dat_o = wbm_dat_i while BUSY, else 0.
- Watchdog:
  - While BUSY and wbm_stb_o=1 and wbm_ack_i=0, count increments, saturating at TIMEOUT.
  - Count clears on ack, on stb low, or on leaving BUSY.
  - When count==TIMEOUT-1 with no ack that cycle, err_pending<=1.
  - The next cycle m_err_o[g]=1 for exactly 1 cycle with wbm_stb_o forced 0; then err_pending clears and count clears.
  - The error response follows exactly TIMEOUT stb cycles without ack.
  - TIMEOUT=0: count never advances; m_err_o is constant 0.
- Simultaneous events:
  - If ack arrives in the same cycle the count reaches TIMEOUT-1, the ack wins and no error is raised.
  - If cyc drops while err_pending is set, err_pending clears and no error pulse is issued.
- Reset mid-transfer: immediate return to IDLE with all outputs 0, even if a slave ack is in flight. A late ack is ignored because gnt=0.
- Masters holding cyc across several stb phases (burst or read-modify-write) keep the grant; there is no preemption.

Decomposition:
- Shared package (wb_pkg): Wishbone width localparams (AW, DW, SELW=DW/8) and the state encodings IDLE=1'b0, BUSY=1'b1.
- Sub-module wb_rr_pick: combinational round-robin picker.
  - Inputs: request vector and last index.
  - Outputs: one-hot grant and encoded index.
  - Reusable by other arbiters.
- The watchdog stays inline.

Test Plan:
- Reset then m_cyc_i=2'b11 in the same cycle -> gnt_o=2'b01 after 1 cycle; when master 0 drops cyc, gnt_o=2'b10 two cycles later.
- Master 1 reads adr 32'h2100_0000, slave acks after 3 cycles with 32'hA5A5_0001 -> m_ack_o=2'b10 for 1 cycle, m_dat_o=32'hA5A5_0001, m_ack_o[0] stays 0.
- TIMEOUT=8, master 0 strobes adr 32'h3000_0000 and no ack comes -> m_err_o[0]=1 exactly 1 cycle after 8 stb cycles; wbm_stb_o=0 in the error cycle.
- TIMEOUT=8, ack arrives on the 8th stb cycle -> m_ack_o[0]=1 and m_err_o stays 0.
- Master 0 holds cyc across 4 stb/ack phases while master 1 requests -> gnt_o stays 2'b01 throughout; master 1 is granted only after master 0 drops cyc.
- wb_rstn_i pulsed low mid-transfer while BUSY -> all wbm_*, gnt_o, m_ack_o and m_err_o go to 0 immediately (asynchronously); after release, master 0 wins the first contention.
